// File: rtl/vin_source_ctrl.sv
// vin_source_ctrl: qualifies the FPD-Link and DPI video inputs from their
// VSYNC timing, picks the active source and mutes the output around every
// source change so downstream logic only ever sees whole frames.
module vin_source_ctrl #(
  parameter int CNT_W       = 24,
  parameter int TIMEOUT     = 2_000_000,
  parameter int TOL         = 16,
  parameter int LOCK_FRAMES = 3,
  parameter int MUTE_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fpd_vsync,
  input  logic             fpd_lock,
  input  logic             dpi_vsync,
  input  logic [1:0]       mode,
  output logic             sel,
  output logic             active,
  output logic             mute,
  output logic             switch_pulse,
  output logic             fpd_alive,
  output logic             dpi_alive,
  output logic [CNT_W-1:0] fpd_period,
  output logic [CNT_W-1:0] dpi_period
);

  localparam int GOOD_W  = $clog2(LOCK_FRAMES + 1);
  localparam int FRAME_W = $clog2(MUTE_FRAMES + 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]     TOL_C     = (CNT_W+1)'(TOL);
  localparam logic [GOOD_W-1:0]  LOCK_C    = GOOD_W'(LOCK_FRAMES);
  localparam logic [FRAME_W-1:0] MUTE_C    = FRAME_W'(MUTE_FRAMES);

  // Source index 0 is DPI, index 1 is FPD-Link (matches the sel encoding).
  logic [1:0]       vs_in;
  logic [1:0]       qual_en;
  logic [1:0]       edge_vec;
  logic [1:0]       alive_vec;
  logic [CNT_W-1:0] period_arr [2];

  assign vs_in   = {fpd_vsync, dpi_vsync};
  assign qual_en = {fpd_lock, 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mon
      logic                vs_q;
      logic                edge_q;
      logic                meas_valid;
      logic                meas_next;
      logic                alive_reg;
      logic [CNT_W-1:0]    cnt_reg;
      logic [CNT_W-1:0]    cnt_next;
      logic [CNT_W-1:0]    period_reg;
      logic [CNT_W-1:0]    period_next;
      logic [GOOD_W-1:0]   good_reg;
      logic [GOOD_W-1:0]   good_next;
      logic signed [CNT_W:0] diff;
      logic [CNT_W:0]      diff_abs;

      // Next state of the frame-period measurement and stability count.
      always_comb begin
        diff        = $signed({1'b0, cnt_reg}) - $signed({1'b0, period_reg});
        diff_abs    = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
        cnt_next    = cnt_reg;
        period_next = period_reg;
        good_next   = good_reg;
        meas_next   = meas_valid;
        if (edge_q) begin
          // The edge cycle is the first cycle of the new frame, so a VSYNC
          // every N clocks measures a period of exactly N.
          cnt_next = CNT_W'(1);
          if (meas_valid) begin
            period_next = cnt_reg;
            if (diff_abs <= TOL_C) begin
              good_next = (good_reg == LOCK_C) ? good_reg : good_reg + GOOD_W'(1);
            end else begin
              good_next = '0;
            end
          end else begin
            meas_next = 1'b1;
            good_next = '0;
          end
        end else if (cnt_reg == TIMEOUT_C) begin
          meas_next   = 1'b0;
          good_next   = '0;
          period_next = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
        if (!qual_en[gi]) begin
          meas_next = 1'b0;
          good_next = '0;
        end
      end

      // Edge detection and monitor state registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vs_q       <= 1'b0;
          edge_q     <= 1'b0;
          meas_valid <= 1'b0;
          cnt_reg    <= '0;
          period_reg <= '0;
          good_reg   <= '0;
          alive_reg  <= 1'b0;
        end else begin
          vs_q       <= vs_in[gi];
          edge_q     <= vs_in[gi] & ~vs_q;
          meas_valid <= meas_next;
          cnt_reg    <= cnt_next;
          period_reg <= period_next;
          good_reg   <= good_next;
          alive_reg  <= (good_next == LOCK_C);
        end
      end

      assign edge_vec[gi]   = edge_q;
      assign alive_vec[gi]  = alive_reg;
      assign period_arr[gi] = period_reg;
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_SWITCH, S_SETTLE, S_RUN} state_t;

  state_t             state_reg;
  logic               target_reg;
  logic [FRAME_W-1:0] frame_cnt_reg;
  logic               sel_reg;
  logic               active_reg;
  logic               mute_reg;
  logic               pulse_reg;
  logic               des_valid;
  logic               des_src;

  // Desired source from the registered alive flags and the requested mode.
  always_comb begin
    des_valid = 1'b0;
    des_src   = 1'b0;
    case (mode)
      2'b00: begin
        if (alive_vec[1]) begin
          des_valid = 1'b1;
          des_src   = 1'b1;
        end else if (alive_vec[0]) begin
          des_valid = 1'b1;
        end
      end
      2'b01: des_valid = alive_vec[0];
      2'b10: begin
        des_valid = alive_vec[1];
        des_src   = 1'b1;
      end
      default: des_valid = 1'b0;
    endcase
  end

  // Selection FSM; desired-source changes take priority over VSYNC events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      target_reg    <= 1'b0;
      frame_cnt_reg <= '0;
      sel_reg       <= 1'b0;
      active_reg    <= 1'b0;
      mute_reg      <= 1'b1;
      pulse_reg     <= 1'b0;
    end else begin
      pulse_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (des_valid) begin
            state_reg  <= S_SWITCH;
            target_reg <= des_src;
          end
        end
        S_SWITCH: begin
          if (!des_valid) begin
            state_reg <= S_IDLE;
          end else if (des_src != target_reg) begin
            target_reg <= des_src;
          end else if (edge_vec[target_reg]) begin
            sel_reg       <= target_reg;
            pulse_reg     <= 1'b1;
            frame_cnt_reg <= '0;
            state_reg     <= S_SETTLE;
            active_reg    <= 1'b1;
          end
        end
        S_SETTLE, S_RUN: begin
          if (!des_valid) begin
            state_reg  <= S_IDLE;
            active_reg <= 1'b0;
            mute_reg   <= 1'b1;
          end else if (des_src != sel_reg) begin
            state_reg  <= S_SWITCH;
            target_reg <= des_src;
            active_reg <= 1'b0;
            mute_reg   <= 1'b1;
          end else if (state_reg == S_SETTLE && edge_vec[sel_reg]) begin
            frame_cnt_reg <= frame_cnt_reg + FRAME_W'(1);
            if (frame_cnt_reg + FRAME_W'(1) == MUTE_C) begin
              state_reg <= S_RUN;
              mute_reg  <= 1'b0;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign sel          = sel_reg;
  assign active       = active_reg;
  assign mute         = mute_reg;
  assign switch_pulse = pulse_reg;
  assign fpd_alive    = alive_vec[1];
  assign dpi_alive    = alive_vec[0];
  assign fpd_period   = period_arr[1];
  assign dpi_period   = period_arr[0];

endmodule

// File: tb/tb_vin_source_ctrl.sv
// tb_vin_source_ctrl: randomized VSYNC/lock/mode stimulus with a
// frame-level reference model feeding a scoreboard of expected outputs.
module tb_vin_source_ctrl;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 200;
  localparam int TOL     = 2;
  localparam int LOCK    = 3;
  localparam int MUTE    = 2;

  localparam int ST_IDLE   = 0;
  localparam int ST_SW     = 1;
  localparam int ST_SETTLE = 2;
  localparam int ST_RUN    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fpd_vsync = 1'b0;
  logic             fpd_lock = 1'b0;
  logic             dpi_vsync = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             sel, active, mute, switch_pulse, fpd_alive, dpi_alive;
  logic [CNT_W-1:0] fpd_period, dpi_period;

  always #5 clk = ~clk;

  vin_source_ctrl #(
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TOL(TOL),
    .LOCK_FRAMES(LOCK), .MUTE_FRAMES(MUTE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fpd_vsync(fpd_vsync), .fpd_lock(fpd_lock),
    .dpi_vsync(dpi_vsync), .mode(mode), .sel(sel), .active(active),
    .mute(mute), .switch_pulse(switch_pulse), .fpd_alive(fpd_alive),
    .dpi_alive(dpi_alive), .fpd_period(fpd_period), .dpi_period(dpi_period)
  );

  typedef struct {
    logic sel; logic active; logic mute; logic pulse;
    logic fa;  logic da;     int   fp;   int   dp;
  } exp_t;

  exp_t exp_q[$];
  int   sw_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (index 0 DPI, 1 FPD-Link)
  int m_cyc;
  int m_prev[2], m_pend[2], m_last[2], m_armed[2], m_good[2], m_per[2], m_alive[2];
  int m_st, m_tgt, m_sel, m_fc;

  // Stimulus generator state
  int pos[2], per[2], base[2], jit[2], on[2], alt[2], altph[2];
  logic [1:0] cur_mode;

  task automatic note_fail(input string msg);
    errors++;
    $display("FAIL %s", msg);
  endtask

  task automatic model_reset();
    m_cyc = 0;
    for (int s = 0; s < 2; s++) begin
      m_prev[s] = 0; m_pend[s] = 0; m_last[s] = 1; m_armed[s] = 0;
      m_good[s] = 0; m_per[s] = 0; m_alive[s] = 0;
    end
    m_st = ST_IDLE; m_tgt = 0; m_sel = 0; m_fc = 0;
  endtask

  // Advance the model by one clock using the inputs sampled at that edge.
  task automatic model_step(input logic vd, input logic vf, input logic lk, input logic [1:0] md);
    int   des;
    int   ed[2];
    int   v[2];
    int   meas, diff;
    exp_t e;
    m_cyc++;
    des = -1;
    case (md)
      2'b00: if (m_alive[1] != 0) des = 1; else if (m_alive[0] != 0) des = 0;
      2'b01: if (m_alive[0] != 0) des = 0;
      2'b10: if (m_alive[1] != 0) des = 1;
      default: des = -1;
    endcase
    ed = m_pend;
    e.pulse = 1'b0;
    case (m_st)
      ST_IDLE: if (des >= 0) begin m_st = ST_SW; m_tgt = des; end
      ST_SW: begin
        if (des < 0) m_st = ST_IDLE;
        else if (des != m_tgt) m_tgt = des;
        else if (ed[m_tgt] != 0) begin
          m_sel = m_tgt; e.pulse = 1'b1; m_fc = 0; m_st = ST_SETTLE;
          sw_q.push_back(m_sel);
        end
      end
      default: begin
        if (des < 0) m_st = ST_IDLE;
        else if (des != m_sel) begin m_st = ST_SW; m_tgt = des; end
        else if (m_st == ST_SETTLE && ed[m_sel] != 0) begin
          m_fc++;
          if (m_fc >= MUTE) m_st = ST_RUN;
        end
      end
    endcase
    v[0] = int'(vd); v[1] = int'(vf);
    for (int s = 0; s < 2; s++) begin
      if (ed[s] != 0) begin
        if (m_armed[s] != 0) begin
          meas = m_cyc - m_last[s];
          diff = meas - m_per[s];
          if (diff < 0) diff = -diff;
          m_good[s] = (diff <= TOL) ? ((m_good[s] < LOCK) ? m_good[s] + 1 : LOCK) : 0;
          m_per[s] = meas;
        end else begin
          m_armed[s] = 1; m_good[s] = 0;
        end
        m_last[s] = m_cyc;
      end else if (m_cyc - m_last[s] >= TIMEOUT) begin
        m_armed[s] = 0; m_good[s] = 0; m_per[s] = 0;
      end
      if (s == 1 && !lk) begin
        m_armed[s] = 0; m_good[s] = 0;
      end
      m_alive[s] = (m_good[s] == LOCK) ? 1 : 0;
      m_pend[s]  = (v[s] != 0 && m_prev[s] == 0) ? 1 : 0;
      m_prev[s]  = v[s];
    end
    e.sel    = (m_sel != 0);
    e.active = (m_st == ST_SETTLE || m_st == ST_RUN);
    e.mute   = (m_st != ST_RUN);
    e.fa     = (m_alive[1] != 0);
    e.da     = (m_alive[0] != 0);
    e.fp     = m_per[1];
    e.dp     = m_per[0];
    exp_q.push_back(e);
  endtask

  function automatic int next_per(input int s);
    if (alt[s] != 0) begin
      altph[s] = 1 - altph[s];
      return base[s] + 2 * altph[s];
    end
    return base[s] + int'($urandom_range(0, jit[s]));
  endfunction

  task automatic set_src(input int s, input int en, input int b, input int j, input int a);
    base[s] = b; jit[s] = j; alt[s] = a;
    if (en != 0 && on[s] == 0) begin
      pos[s] = 0; altph[s] = 0; per[s] = next_per(s);
    end
    on[s] = en;
  endtask

  function automatic logic gen_vs(input int s);
    logic v;
    if (on[s] == 0) begin
      pos[s] = 0;
      return 1'b0;
    end
    v = (pos[s] < 5);
    pos[s]++;
    if (pos[s] >= per[s]) begin
      pos[s] = 0;
      per[s] = next_per(s);
    end
    return v;
  endfunction

  task automatic run_phase(input int ncyc, input int d_on, input int d_base, input int d_jit,
                           input int d_alt, input int f_on, input int f_base, input int f_jit,
                           input logic lk, input logic [1:0] md, input int mode_rand,
                           input int flip);
    set_src(0, d_on, d_base, d_jit, d_alt);
    set_src(1, f_on, f_base, f_jit, 0);
    fpd_lock = lk;
    cur_mode = md;
    mode     = md;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      model_step(dpi_vsync, fpd_vsync, fpd_lock, mode);
      if (mode_rand != 0 && $urandom_range(0, 199) == 0) cur_mode = 2'($urandom_range(0, 3));
      // Retarget in the very cycle the pending target edge is acted on.
      if (flip != 0 && m_st == ST_SW && m_pend[m_tgt] != 0) begin
        cur_mode = (m_tgt == 1) ? 2'b01 : 2'b10;
        flip = 0;
      end
      mode      = cur_mode;
      dpi_vsync = gen_vs(0);
      fpd_vsync = gen_vs(1);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (sel !== 1'b0 || active !== 1'b0 || mute !== 1'b1 || switch_pulse !== 1'b0 ||
        fpd_alive !== 1'b0 || dpi_alive !== 1'b0 || fpd_period !== '0 || dpi_period !== '0)
      note_fail($sformatf("%s got sel=%0b act=%0b mute=%0b pulse=%0b fa=%0b da=%0b fp=%0d dp=%0d expected 0 0 1 0 0 0 0 0",
                name, sel, active, mute, switch_pulse, fpd_alive, dpi_alive, fpd_period, dpi_period));
  endtask

  // Scoreboard monitor: compares every presented output cycle and switch event.
  initial begin : monitor
    exp_t e;
    int   s;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (sel !== e.sel || active !== e.active || mute !== e.mute || switch_pulse !== e.pulse ||
            fpd_alive !== e.fa || dpi_alive !== e.da ||
            int'(fpd_period) != e.fp || int'(dpi_period) != e.dp)
          note_fail($sformatf("status t=%0t got sel=%0b act=%0b mute=%0b pulse=%0b fa=%0b da=%0b fp=%0d dp=%0d expected sel=%0b act=%0b mute=%0b pulse=%0b fa=%0b da=%0b fp=%0d dp=%0d",
                    $time, sel, active, mute, switch_pulse, fpd_alive, dpi_alive, fpd_period, dpi_period,
                    e.sel, e.active, e.mute, e.pulse, e.fa, e.da, e.fp, e.dp));
      end
      if (switch_pulse === 1'b1 && rst_n === 1'b1) begin
        checks++;
        if (sw_q.size() == 0) begin
          note_fail($sformatf("switch_event t=%0t got pulse with sel=%0b expected no pulse", $time, sel));
        end else begin
          s = sw_q.pop_front();
          if (int'(sel) != s)
            note_fail($sformatf("switch_event t=%0t got sel=%0b expected sel=%0d", $time, sel, s));
        end
      end
    end
  end

  initial begin : stimulus
    model_reset();
    for (int s = 0; s < 2; s++) begin
      on[s] = 0; pos[s] = 0; per[s] = 100; base[s] = 100; jit[s] = 0; alt[s] = 0; altph[s] = 0;
    end
    cur_mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_initial");
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    run_phase(1000, 1, 100, 0, 0, 0, 120, 0, 1'b0, 2'b00, 0, 0); // DPI qualification
    run_phase(1400, 1, 100, 0, 0, 1, 120, 0, 1'b1, 2'b00, 0, 0); // FPD-Link priority
    run_phase(400,  1, 100, 0, 0, 1, 120, 0, 1'b0, 2'b00, 0, 0); // lock dropped
    run_phase(1400, 1, 100, 0, 0, 1, 120, 0, 1'b1, 2'b00, 0, 0); // FPD-Link back
    run_phase(700,  1, 100, 0, 0, 0, 120, 0, 1'b1, 2'b00, 0, 0); // VSYNC stopped, lock held
    run_phase(1500, 1, 100, 3, 0, 0, 120, 0, 1'b0, 2'b00, 0, 0); // jittered DPI
    run_phase(1200, 1, 100, 0, 1, 0, 120, 0, 1'b0, 2'b00, 0, 0); // 100/102 alternating
    run_phase(1400, 1, 100, 0, 0, 1, 120, 0, 1'b1, 2'b00, 0, 0); // both alive, auto
    run_phase(600,  1, 100, 0, 0, 1, 120, 0, 1'b1, 2'b01, 0, 0); // force DPI
    run_phase(500,  1, 100, 0, 0, 0, 120, 0, 1'b0, 2'b10, 0, 0); // force dead FPD-Link
    run_phase(400,  1, 100, 0, 0, 1, 120, 0, 1'b1, 2'b11, 0, 0); // off
    run_phase(1000, 1, 100, 0, 0, 0, 120, 0, 1'b0, 2'b00, 0, 0); // DPI running
    run_phase(1400, 1, 100, 0, 0, 1, 120, 0, 1'b1, 2'b00, 0, 1); // retarget on target edge

    // Asynchronous reset in the middle of a clock cycle
    #2;
    rst_n     = 1'b0;
    dpi_vsync = 1'b0;
    fpd_vsync = 1'b0;
    #1;
    check_reset_values("reset_async");
    exp_q.delete();
    sw_q.delete();
    on[0] = 0; on[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    run_phase(300, 0, 100, 0, 0, 0, 120, 0, 1'b0, 2'b00, 0, 0);

    for (int r = 0; r < 8; r++)
      run_phase(800, int'($urandom_range(0, 3) != 0), int'($urandom_range(60, 150)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)), int'($urandom_range(60, 150)),
                int'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0),
                2'($urandom_range(0, 3)), 1, 0);

    @(negedge clk);
    #1;
    checks++;
    if (sw_q.size() != 0 || exp_q.size() != 0)
      note_fail($sformatf("drain got %0d switch events and %0d status entries outstanding expected 0 and 0",
                sw_q.size(), exp_q.size()));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
